// File: rtl/pic_host_sequencer.sv
// Host-side bus master that turns write/read/int-ack commands into 8259 pin cycles.
// Latency: write/read busy SETUP+PULSE+1 cycles, int-ack busy 2*PULSE+GAP+1 cycles.
// Backpressure: cmd_ready_o only in IDLE; commands presented while busy are not taken.
module pic_host_sequencer #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic       cmd_a0_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       chip_select_o,
    output logic       write_flag_o,
    output logic       read_flag_o,
    output logic       A0_o,
    output logic       INTA_o,
    output logic [7:0] data_out_o,
    output logic       data_oe_o,
    input  logic [7:0] data_in_i,
    input  logic       INT_i,
    output logic       int_pending_o
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_INTA  = 2'b10;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_ACK1,
        S_ACK_GAP,
        S_ACK2,
        S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic       a0_q, a0_d;
    logic [7:0] wdat_q, wdat_d;

    // Registered pin/response outputs and their next values.
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       cs_q, cs_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       a0_pin_q, a0_pin_d;
    logic       inta_q, inta_d;
    logic [7:0] dout_q, dout_d;
    logic       oe_q, oe_d;
    logic       int_meta_q, int_sync_q;

    logic       access;
    logic       is_wr;
    logic       is_rd;

    // State register: FSM state, phase counter and the command latched at acceptance.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a0_q    <= 1'b0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a0_q    <= a0_d;
            wdat_q  <= wdat_d;
        end
    end

    // Next-state logic: each timed phase runs its counter to the last cycle, then advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a0_d    = a0_q;
        wdat_d  = wdat_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Ready is high in IDLE, so valid alone means acceptance here.
                if (cmd_valid_i) begin
                    op_d   = cmd_op_i;
                    a0_d   = cmd_a0_i;
                    wdat_d = cmd_data_i;
                    case (cmd_op_i)
                        OP_WRITE, OP_READ: state_d = S_SETUP;
                        OP_INTA:           state_d = S_ACK1;
                        default:           state_d = S_IDLE; // reserved op is swallowed
                    endcase
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            S_ACK1: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_ACK_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_ACK2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK2: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: pins are decoded from the next state so the registered copy lines up
    // with state_q and every strobe toggles exactly once per pulse with no glitches.
    always_comb begin
        access      = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        is_wr       = (op_d == OP_WRITE);
        is_rd       = (op_d == OP_READ);
        cmd_ready_d = (state_d == S_IDLE);
        cs_d        = !access;
        wr_d        = !((state_d == S_STROBE) && is_wr);
        rd_d        = !((state_d == S_STROBE) && is_rd);
        inta_d      = !((state_d == S_ACK1) || (state_d == S_ACK2));
        a0_pin_d    = access ? a0_d : 1'b0;
        oe_d        = access && is_wr;
        dout_d      = (access && is_wr) ? wdat_d : 8'h00;
        // HOLD and RESP last one cycle, so entering them yields a single-cycle pulse and
        // data_in is captured on the final strobe cycle.
        rsp_valid_d = ((state_d == S_HOLD) && is_rd) || (state_d == S_RESP);
        rsp_data_d  = rsp_valid_d ? data_in_i : rsp_data_q;
    end

    // Output registers with their reset (idle-bus) values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cs_q        <= 1'b1;
            wr_q        <= 1'b1;
            rd_q        <= 1'b1;
            a0_pin_q    <= 1'b0;
            inta_q      <= 1'b1;
            dout_q      <= '0;
            oe_q        <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            a0_pin_q    <= a0_pin_d;
            inta_q      <= inta_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    // Two-flop synchroniser for the asynchronous PIC interrupt line.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            int_meta_q <= INT_i;
            int_sync_q <= int_meta_q;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign chip_select_o = cs_q;
    assign write_flag_o  = wr_q;
    assign read_flag_o   = rd_q;
    assign A0_o          = a0_pin_q;
    assign INTA_o        = inta_q;
    assign data_out_o    = dout_q;
    assign data_oe_o     = oe_q;
    assign int_pending_o = int_sync_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer: per-cycle pin traces compared against
// hand-derived waveforms for default timing and for a PULSE_CYCLES=4 instance.
module tb_pic_host_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cmd_valid;
    logic       sel_b;
    logic [1:0] cmd_op;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic [7:0] data_in;
    logic       int_in;

    logic       valid_a, valid_b;
    logic       rdy_a, rv_a, cs_a, wr_a, rd_a, a0_a, inta_a, oe_a, ip_a;
    logic [7:0] rdat_a, dout_a;
    logic       rdy_b, rv_b, cs_b, wr_b, rd_b, a0_b, inta_b, oe_b, ip_b;
    logic [7:0] rdat_b, dout_b;

    assign valid_a = cmd_valid && !sel_b;
    assign valid_b = cmd_valid && sel_b;

    pic_host_sequencer dut_a (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(valid_a), .cmd_ready_o(rdy_a),
        .cmd_op_i(cmd_op), .cmd_a0_i(cmd_a0), .cmd_data_i(cmd_data),
        .rsp_valid_o(rv_a), .rsp_data_o(rdat_a), .chip_select_o(cs_a),
        .write_flag_o(wr_a), .read_flag_o(rd_a), .A0_o(a0_a), .INTA_o(inta_a),
        .data_out_o(dout_a), .data_oe_o(oe_a), .data_in_i(data_in), .INT_i(int_in),
        .int_pending_o(ip_a)
    );

    pic_host_sequencer #(.SETUP_CYCLES(1), .PULSE_CYCLES(4), .GAP_CYCLES(1)) dut_b (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(valid_b), .cmd_ready_o(rdy_b),
        .cmd_op_i(cmd_op), .cmd_a0_i(cmd_a0), .cmd_data_i(cmd_data),
        .rsp_valid_o(rv_b), .rsp_data_o(rdat_b), .chip_select_o(cs_b),
        .write_flag_o(wr_b), .read_flag_o(rd_b), .A0_o(a0_b), .INTA_o(inta_b),
        .data_out_o(dout_b), .data_oe_o(oe_b), .data_in_i(data_in), .INT_i(int_in),
        .int_pending_o(ip_b)
    );

    // Selected-DUT view used by the trace capture.
    logic       rdy_s, rv_s, cs_s, wr_s, rd_s, a0_s, inta_s, oe_s;
    logic [7:0] rdat_s, dout_s;
    assign rdy_s  = sel_b ? rdy_b  : rdy_a;
    assign rv_s   = sel_b ? rv_b   : rv_a;
    assign cs_s   = sel_b ? cs_b   : cs_a;
    assign wr_s   = sel_b ? wr_b   : wr_a;
    assign rd_s   = sel_b ? rd_b   : rd_a;
    assign a0_s   = sel_b ? a0_b   : a0_a;
    assign inta_s = sel_b ? inta_b : inta_a;
    assign oe_s   = sel_b ? oe_b   : oe_a;
    assign rdat_s = sel_b ? rdat_b : rdat_a;
    assign dout_s = sel_b ? dout_b : dout_a;

    // Trace bit (c-1) holds the value seen in cycle c after the acceptance edge.
    logic [23:0] cs_tr, wr_tr, rd_tr, inta_tr, oe_tr, rv_tr, rdy_tr;
    logic [7:0]  dout_tr [1:24];
    logic        a0_tr   [1:24];
    logic [7:0]  rdat_tr [1:24];

    logic [1:0]  s_op  [0:7];
    logic        s_a0  [0:7];
    logic [7:0]  s_dat [0:7];
    int          s_n;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents s_op/s_a0/s_dat[0..s_n-1] with valid held until each is accepted and records
    // ncyc cycles of pins. Optional data_in change and a one-cycle reset at given cycles.
    task automatic run_seq(input int ncyc, input int dsw_cyc, input logic [7:0] dsw_val,
                           input int rst_cyc);
        int   idx;
        logic acc;
        cs_tr = '0; wr_tr = '0; rd_tr = '0; inta_tr = '0; oe_tr = '0; rv_tr = '0; rdy_tr = '0;
        for (int i = 1; i <= 24; i++) begin
            dout_tr[i] = '0; a0_tr[i] = 1'b0; rdat_tr[i] = '0;
        end
        idx       = 0;
        cmd_op    = s_op[0];
        cmd_a0    = s_a0[0];
        cmd_data  = s_dat[0];
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        idx = 1;
        if (idx < s_n) begin
            cmd_op = s_op[idx]; cmd_a0 = s_a0[idx]; cmd_data = s_dat[idx];
        end else begin
            cmd_valid = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == dsw_cyc) data_in = dsw_val;
            if (c == rst_cyc) reset = 1'b1;
            cs_tr[c-1]   = cs_s;
            wr_tr[c-1]   = wr_s;
            rd_tr[c-1]   = rd_s;
            inta_tr[c-1] = inta_s;
            oe_tr[c-1]   = oe_s;
            rv_tr[c-1]   = rv_s;
            rdy_tr[c-1]  = rdy_s;
            dout_tr[c]   = dout_s;
            a0_tr[c]     = a0_s;
            rdat_tr[c]   = rdat_s;
            acc = cmd_valid && rdy_s;
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (acc) begin
                idx++;
                if (idx < s_n) begin
                    cmd_op = s_op[idx]; cmd_a0 = s_a0[idx]; cmd_data = s_dat[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; sel_b = 1'b0; cmd_op = 2'b00; cmd_a0 = 1'b0;
        cmd_data = 8'h00; data_in = 8'h00; int_in = 1'b0; s_n = 0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl_a", 24'({rdy_a, rv_a, cs_a, wr_a, rd_a, inta_a, a0_a, oe_a}), 24'hBC);
        check("rst_ctl_b", 24'({rdy_b, rv_b, cs_b, wr_b, rd_b, inta_b, a0_b, oe_b}), 24'hBC);
        check("rst_data", 24'({rdat_a, dout_a}), 24'h0);
        check("rst_intp", 24'(ip_a), 24'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ICW1 write
        s_n = 1; s_op[0] = 2'b00; s_a0[0] = 1'b0; s_dat[0] = 8'h1A;
        run_seq(8, 0, 8'h00, 0);
        check("icw1_cs",   cs_tr,   24'h0000F0);
        check("icw1_wr",   wr_tr,   24'h0000F9);
        check("icw1_rd",   rd_tr,   24'h0000FF);
        check("icw1_inta", inta_tr, 24'h0000FF);
        check("icw1_oe",   oe_tr,   24'h00000F);
        check("icw1_rdy",  rdy_tr,  24'h0000F0);
        check("icw1_rv",   rv_tr,   24'h000000);
        check("icw1_dout", 24'({dout_tr[1], dout_tr[3]}), 24'h1A1A);
        check("icw1_a0",   24'(a0_tr[1]), 24'h0);

        // ICW2-4 + OCW back-to-back
        s_n = 4;
        s_op[0] = 2'b00; s_a0[0] = 1'b1; s_dat[0] = 8'hF8;
        s_op[1] = 2'b00; s_a0[1] = 1'b1; s_dat[1] = 8'h00;
        s_op[2] = 2'b00; s_a0[2] = 1'b1; s_dat[2] = 8'h0F;
        s_op[3] = 2'b00; s_a0[3] = 1'b0; s_dat[3] = 8'h00;
        run_seq(20, 0, 8'h00, 0);
        check("b2b_cs",   cs_tr,  24'h084210);
        check("b2b_rdy",  rdy_tr, 24'h084210);
        check("b2b_wr",   wr_tr,  24'h0CE739);
        check("b2b_dout", {dout_tr[1], dout_tr[6], dout_tr[11]}, 24'hF8000F);
        check("b2b_dout3", 24'(dout_tr[16]), 24'h00);
        check("b2b_a0", 24'({a0_tr[1], a0_tr[6], a0_tr[11], a0_tr[16]}), 24'hE);

        // Register read
        data_in = 8'h10;
        s_n = 1; s_op[0] = 2'b01; s_a0[0] = 1'b0; s_dat[0] = 8'h00;
        run_seq(8, 0, 8'h00, 0);
        check("rd_cs",   cs_tr, 24'h0000F0);
        check("rd_rd",   rd_tr, 24'h0000F9);
        check("rd_wr",   wr_tr, 24'h0000FF);
        check("rd_oe",   oe_tr, 24'h000000);
        check("rd_rv",   rv_tr, 24'h000008);
        check("rd_data", 24'({rdat_tr[3], rdat_tr[4], rdat_tr[8]}), 24'h001010);

        // INT synchroniser latency
        @(posedge clk);
        #1 int_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("intp_one_edge", 24'(ip_a), 24'h0);
        @(negedge clk);
        check("intp_two_edge", 24'(ip_a), 24'h1);

        // Interrupt acknowledge, vector appears only during second pulse
        data_in = 8'h00;
        s_n = 1; s_op[0] = 2'b10; s_a0[0] = 1'b0; s_dat[0] = 8'h00;
        run_seq(8, 4, 8'hFC, 0);
        check("ack_inta", inta_tr, 24'h0000E4);
        check("ack_cs",   cs_tr,   24'h0000FF);
        check("ack_wrrd", {wr_tr[7:0], rd_tr[7:0], oe_tr[7:0]}, 24'hFFFF00);
        check("ack_rv",   rv_tr,   24'h000020);
        check("ack_vec",  24'(rdat_tr[6]), 24'hFC);
        check("ack_rdy",  rdy_tr,  24'h0000C0);
        check("ack_intp", 24'(ip_a), 24'h1);
        int_in = 1'b0;

        // Reset in the middle of an int-ack
        data_in = 8'h55;
        run_seq(8, 0, 8'h00, 3);
        check("rst_mid_inta", inta_tr, 24'h0000FC);
        check("rst_mid_rdy",  rdy_tr,  24'h0000F8);
        check("rst_mid_rv",   rv_tr,   24'h000000);
        check("rst_mid_rdat", 24'(rdat_tr[8]), 24'h00);

        // Reserved op
        s_op[0] = 2'b11; s_dat[0] = 8'hA5;
        run_seq(8, 0, 8'h00, 0);
        check("op11_pins", {cs_tr[7:0], wr_tr[7:0], rd_tr[7:0]}, 24'hFFFFFF);
        check("op11_inta", inta_tr, 24'h0000FF);
        check("op11_oe_rv", {oe_tr[7:0], rv_tr[7:0]}, 24'h0000);
        check("op11_rdy", rdy_tr, 24'h0000FF);

        // Write with PULSE_CYCLES=4
        sel_b = 1'b1;
        s_op[0] = 2'b00; s_a0[0] = 1'b1; s_dat[0] = 8'h1A;
        run_seq(8, 0, 8'h00, 0);
        check("p4_cs",  cs_tr,  24'h0000C0);
        check("p4_wr",  wr_tr,  24'h0000E1);
        check("p4_oe",  oe_tr,  24'h00003F);
        check("p4_rdy", rdy_tr, 24'h0000C0);
        check("p4_dout", 24'({a0_tr[5], dout_tr[5]}), 24'h11A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
